// File: rtl/ale_frame_ctrl.sv
// Frame sequencer for the atmospheric light estimator: pass-1 gating/drain, serial 1/A, pass 2.
// Optional: define ALE_BORDER_SKIP_EN to mask border windows from the estimator.
module ale_frame_ctrl #(
  parameter int unsigned IMG_W   = 512,
  parameter int unsigned IMG_H   = 512,
  parameter int unsigned ALE_LAT = 4,
  parameter int unsigned CNT_W   = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        win_valid,
  input  logic        pix_valid,
  input  logic [7:0]  ale_a_r,
  input  logic [7:0]  ale_a_g,
  input  logic [7:0]  ale_a_b,
  output logic        ale_clear,
  output logic        ale_in_valid,
  output logic [7:0]  a_r,
  output logic [7:0]  a_g,
  output logic [7:0]  a_b,
  output logic [15:0] inv_a_r,
  output logic [15:0] inv_a_g,
  output logic [15:0] inv_a_b,
  output logic        a_valid,
  output logic        pass2_en,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StInv   = 3'd3;
  localparam logic [2:0] StPass2 = 3'd4;

  localparam int unsigned DRAIN_W = (ALE_LAT > 1) ? $clog2(ALE_LAT) : 1;
  // Last index rather than the total so a full power-of-two frame fits CNT_W.
  localparam logic [CNT_W-1:0]   PIX_LAST   = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ALE_LAT - 1);

  logic [2:0]         state_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [4:0]         div_cnt_q;
  logic [1:0]         ch_q;
  logic [7:0]         rem_q;
  logic [14:0]        quo_q;

  logic [7:0] div_d;
  logic [8:0] rem_sh;
  logic       ge;
  logic       fwd_ok;

`ifdef ALE_BORDER_SKIP_EN
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  assign fwd_ok = (row_q != '0) && (row_q != ROW_W'(IMG_H - 1)) &&
                  (col_q != '0) && (col_q != COL_W'(IMG_W - 1));
`else
  assign fwd_ok = 1'b1;
`endif

  assign ale_in_valid = win_valid && (state_q == StRun) && fwd_ok;
  assign pass2_en     = (state_q == StPass2);
  assign busy         = (state_q != StIdle);

  always_comb begin
    div_d = a_r;
    case (ch_q)
      2'd1:    div_d = a_g;
      2'd2:    div_d = a_b;
      default: div_d = a_r;
    endcase
  end

  // One restoring step; remainder stays below the divisor so 8 bits suffice.
  assign rem_sh = {rem_q, 1'b0};
  assign ge     = (rem_sh >= {1'b0, div_d});

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      div_cnt_q   <= '0;
      ch_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      ale_clear   <= 1'b0;
      done        <= 1'b0;
      a_valid     <= 1'b0;
      a_r         <= '0;
      a_g         <= '0;
      a_b         <= '0;
      inv_a_r     <= '0;
      inv_a_g     <= '0;
      inv_a_b     <= '0;
`ifdef ALE_BORDER_SKIP_EN
      col_q       <= '0;
      row_q       <= '0;
`endif
    end else begin
      ale_clear <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            ale_clear <= 1'b1;
            pix_cnt_q <= '0;
            a_valid   <= 1'b0;
`ifdef ALE_BORDER_SKIP_EN
            col_q     <= '0;
            row_q     <= '0;
`endif
          end
        end
        StRun: begin
          if (win_valid) begin
            if (pix_cnt_q == PIX_LAST) begin
              state_q     <= StDrain;
              pix_cnt_q   <= '0;
              drain_cnt_q <= '0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
`ifdef ALE_BORDER_SKIP_EN
            if (col_q == COL_W'(IMG_W - 1)) begin
              col_q <= '0;
              row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
`endif
          end
        end
        StDrain: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q   <= StInv;
            a_r       <= ale_a_r;
            a_g       <= ale_a_g;
            a_b       <= ale_a_b;
            ch_q      <= '0;
            div_cnt_q <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        StInv: begin
          if (div_cnt_q == 5'd0) begin
            // 2^16 dividend: its leading one is already the first partial remainder.
            rem_q     <= 8'd1;
            quo_q     <= '0;
            div_cnt_q <= 5'd1;
          end else begin
            rem_q <= 8'(ge ? (rem_sh - {1'b0, div_d}) : rem_sh);
            quo_q <= {quo_q[13:0], ge};
            if (div_cnt_q == 5'd16) begin
              div_cnt_q <= 5'd0;
              case (ch_q)
                2'd0:    inv_a_r <= (div_d < 8'd2) ? 16'hFFFF : {quo_q, ge};
                2'd1:    inv_a_g <= (div_d < 8'd2) ? 16'hFFFF : {quo_q, ge};
                default: inv_a_b <= (div_d < 8'd2) ? 16'hFFFF : {quo_q, ge};
              endcase
              if (ch_q == 2'd2) begin
                state_q   <= StPass2;
                pix_cnt_q <= '0;
                a_valid   <= 1'b1;
              end else begin
                ch_q <= ch_q + 1'b1;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
          end
        end
        StPass2: begin
          if (pix_valid) begin
            if (pix_cnt_q == PIX_LAST) begin
              state_q   <= StIdle;
              pix_cnt_q <= '0;
              done      <= 1'b1;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ale_frame_ctrl.sv
// Directed bench for ale_frame_ctrl on a 4x3 frame: vector table of A values plus abort sequences.
module tb_ale_frame_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;
  localparam int unsigned LAT = 4;
`ifdef ALE_BORDER_SKIP_EN
  localparam int ExpIv = 2;
`else
  localparam int ExpIv = 12;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, win_valid, pix_valid;
  logic [7:0]  ale_a_r, ale_a_g, ale_a_b;
  logic        ale_clear, ale_in_valid, a_valid, pass2_en, busy, done;
  logic [7:0]  a_r, a_g, a_b;
  logic [15:0] inv_a_r, inv_a_g, inv_a_b;

  ale_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ALE_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_valid(win_valid), .pix_valid(pix_valid),
    .ale_a_r(ale_a_r), .ale_a_g(ale_a_g), .ale_a_b(ale_a_b),
    .ale_clear(ale_clear), .ale_in_valid(ale_in_valid),
    .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
    .a_valid(a_valid), .pass2_en(pass2_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ar, ag, ab;
    logic [15:0] ir, ig, ib;
  } vec_t;

  vec_t vecs [3];
  vec_t vab;
  int errors = 0;
  int checks = 0;
  int iv_cnt = 0;
  int clr_cnt = 0;
  int done_cnt = 0;
  logic [7:0] last_ar;

  always @(negedge clk) begin
    if (ale_in_valid) iv_cnt <= iv_cnt + 1;
    if (ale_clear)    clr_cnt <= clr_cnt + 1;
    if (done)         done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ale_clear_pulse", 32'(ale_clear), 1);
    chk("busy_after_start", 32'(busy), 1);
    chk("a_valid_drop_on_start", 32'(a_valid), 0);
  endtask

  // Twelve window valids with gaps; returns in the cycle after the final one.
  task automatic feed_frame();
    for (int i = 0; i < 12; i++) begin
      win_valid = 1'b1;
      step();
      if (i % 3 == 1) begin
        win_valid = 1'b0;
        step();
      end
    end
    win_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int c0, i0, d0;
    ale_a_r = v.ar; ale_a_g = v.ag; ale_a_b = v.ab;
    c0 = clr_cnt; i0 = iv_cnt; d0 = done_cnt;
    do_start();
    step();
    chk("ale_clear_one_cycle", 32'(ale_clear), 0);
    start = 1'b1;  // ignored while busy
    step();
    start = 1'b0;
    feed_frame();
    chk("ale_clear_count", 32'(clr_cnt - c0), 1);
    win_valid = 1'b1;
    #1;
    chk("no_fwd_after_last", 32'(ale_in_valid), 0);
    step(); step(); step();
    win_valid = 1'b0;
    chk("in_valid_count", 32'(iv_cnt - i0), 32'(ExpIv));
    chk("a_r_before_inv", 32'(a_r), 32'(last_ar));
    step();
    chk("a_r_latched", 32'(a_r), 32'(v.ar));
    chk("a_g_latched", 32'(a_g), 32'(v.ag));
    chk("a_b_latched", 32'(a_b), 32'(v.ab));
    repeat (50) step();
    chk("a_valid_before_51", 32'(a_valid), 0);
    step();
    chk("a_valid_at_51", 32'(a_valid), 1);
    chk("pass2_en", 32'(pass2_en), 1);
    chk("inv_a_r", 32'(inv_a_r), 32'(v.ir));
    chk("inv_a_g", 32'(inv_a_g), 32'(v.ig));
    chk("inv_a_b", 32'(inv_a_b), 32'(v.ib));
    for (int i = 0; i < 11; i++) begin
      pix_valid = 1'b1;
      step();
      pix_valid = 1'b0;
      if (i % 3 == 0) step();
    end
    chk("no_early_done", 32'(done_cnt - d0), 0);
    chk("busy_before_last_pix", 32'(busy), 1);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("busy_after_done", 32'(busy), 0);
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("pass2_en_idle", 32'(pass2_en), 0);
    repeat (3) step();
    chk("a_valid_held", 32'(a_valid), 1);
    chk("a_r_held", 32'(a_r), 32'(v.ar));
    chk("inv_a_b_held", 32'(inv_a_b), 32'(v.ib));
    last_ar = v.ar;
  endtask

  initial begin
    vecs[0] = '{ar: 8'd200, ag: 8'd128, ab: 8'd1,  ir: 16'd327,   ig: 16'd512,   ib: 16'hFFFF};
    vecs[1] = '{ar: 8'd0,   ag: 8'd255, ab: 8'd2,  ir: 16'hFFFF,  ig: 16'd257,   ib: 16'd32768};
    vecs[2] = '{ar: 8'd255, ag: 8'd3,   ab: 8'd16, ir: 16'd257,   ig: 16'd21845, ib: 16'd4096};
    vab     = '{ar: 8'd100, ag: 8'd50,  ab: 8'd25, ir: 16'd655,   ig: 16'd1310,  ib: 16'd2621};
    last_ar = 8'd0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; win_valid = 1'b0; pix_valid = 1'b0;
    ale_a_r = 8'd0; ale_a_g = 8'd0; ale_a_b = 8'd0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_pass2_en", 32'(pass2_en), 0);
    chk("rst_ale_clear", 32'(ale_clear), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_a_r", 32'(a_r), 0);
    chk("rst_inv_a_r", 32'(inv_a_r), 0);
    win_valid = 1'b1;
    #1;
    chk("idle_no_fwd", 32'(ale_in_valid), 0);
    step();
    win_valid = 1'b0;
    chk("idle_win_no_start", 32'(busy), 0);

    for (int k = 0; k < 3; k++) run_frame(vecs[k]);

    // Abort in the middle of the G channel of the divider.
    ale_a_r = vab.ar; ale_a_g = vab.ag; ale_a_b = vab.ab;
    do_start();
    feed_frame();
    repeat (4) step();
    chk("abort_a_r_latched", 32'(a_r), 32'(vab.ar));
    repeat (18) step();
    chk("abort_r_written", 32'(inv_a_r), 32'(vab.ir));
    chk("abort_g_pending", 32'(inv_a_g), 32'(vecs[2].ig));
    repeat (2) step();
    abort = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_a_valid", 32'(a_valid), 0);
      chk("abort_pass2_en", 32'(pass2_en), 0);
      chk("abort_inv_a_r", 32'(inv_a_r), 0);
      chk("abort_inv_a_g", 32'(inv_a_g), 0);
      chk("abort_a_r", 32'(a_r), 0);
      repeat (60) step();
      chk("abort_no_done", 32'(done_cnt - d0), 0);
      chk("abort_stays_idle", 32'(busy), 0);
    end

    // Abort wins over a simultaneous start.
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_no_clear", 32'(ale_clear), 0);
    last_ar = 8'd0;
    run_frame(vab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
